// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory access port.
//   state_e              - access FSM states (IDLE/BUSY/DONE)
//   DMEM_ERR_DATA        - load data returned when an access times out
//   DMEM_TIMEOUT_DEFAULT - default BUSY cycles without ack before abort
package dmem_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DMEM_ERR_DATA        = 32'hDEAD_BEEF;
  localparam int          DMEM_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/dmem_timeout.sv
// dmem_timeout: BUSY-cycle watchdog for dmem_port (used only when the
// DMEM_TIMEOUT_EN macro is defined).
//   clk_i, rst_i  clock / async active-low reset
//   clr_i         zero the counter (held while not BUSY)
//   en_i          count this cycle (BUSY)
//   expired_o     high in the CYCLES-th consecutive enabled cycle
module dmem_timeout
  import dmem_pkg::*;
#(
  parameter int CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Combinational so the FSM leaves BUSY at the end of the CYCLES-th cycle.
  assign expired_o = en_i && (cnt_q == CW'(CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && !expired_o)  cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/dmem_port.sv
// dmem_port: memory-stage access controller. Converts a MemRead/MemWrite
// request from EX/MEM into a registered req/ack bus transaction, stalls the
// pipeline until it completes, and presents load data for MEM/WB.
//   clk_i, rst_i             clock / async active-low reset
//   MemRead_i, MemWrite_i    request from EX/MEM (write wins if both)
//   addr_i, wdata_i          byte address / store data
//   stall_o                  freeze upstream pipeline
//   rdata_o                  load data (holds between loads)
//   mem_req_o/we/addr/wdata  bus request side, registered
//   mem_ack_i, mem_rdata_i   bus completion pulse / read data
//   err_o                    sticky timeout flag
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses that see no ack
// within TIMEOUT_CYCLES BUSY cycles; otherwise BUSY waits forever.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
  state_e state_q, state_d;
  logic   req_any;
  logic   expired;

  assign req_any = MemRead_i | MemWrite_i;

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != S_BUSY),
    .en_i      (state_q == S_BUSY),
    .expired_o (expired)
  );

  // An ack in the expiry cycle is a normal completion, not an error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                          err_o <= 1'b0;
    else if (state_q == S_BUSY && expired && !mem_ack_i) err_o <= 1'b1;
  end
`else
  // Never true; the parameter is still referenced so it elaborates cleanly.
  assign expired = (TIMEOUT_CYCLES < 0);
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_o = req_any;
        if (req_any) state_d = S_BUSY;
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (mem_ack_i || expired) state_d = S_DONE;
      end
      // One unstalled cycle lets the pipeline move past the served
      // instruction before its (still held) request is looked at again.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_o <= (state_d == S_BUSY);
      if (state_q == S_IDLE && req_any) begin
        mem_addr_o  <= {addr_i[31:2], 2'b00};
        mem_wdata_o <= wdata_i;
        mem_we_o    <= MemWrite_i;
      end
      if (state_q == S_BUSY && !mem_we_o) begin
        if (mem_ack_i)    rdata_o <= mem_rdata_i;
        else if (expired) rdata_o <= DMEM_ERR_DATA;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dmem_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
  );

  // One row = one clock cycle: inputs driven just after the rising edge,
  // outputs compared on the falling edge of the same cycle.
  typedef struct {
    logic        rst, rd, wr;
    logic [31:0] addr, wd;
    logic        ack;
    logic [31:0] mrd;
    logic        stall, req, we;
    logic [31:0] maddr, mwd, rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rd, logic wr, logic [31:0] addr,
                              logic [31:0] wd, logic ack, logic [31:0] mrd,
                              logic stall, logic req, logic we,
                              logic [31:0] maddr, logic [31:0] mwd,
                              logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.ack = ack; v.mrd = mrd; v.stall = stall; v.req = req; v.we = we;
    v.maddr = maddr; v.mwd = mwd; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] mrd);
    MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wd;
    mem_ack_i = ack; mem_rdata_i = mrd;
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);

    //            rst rd wr addr         wdata         ack rdata_in      stall req we maddr        mwdata        rdata
    // reset state
    vecs.push_back(mk(0, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0));
    // load 0x13, ack in first BUSY cycle
    vecs.push_back(mk(1, 1, 0, 32'h13,     32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h13,     32'h0,        1, 32'hCAFE0001, 1, 1, 0, 32'h10,  32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h13,     32'h0,        0, 32'h0,        0, 0, 0, 32'h10,  32'h0,        32'hCAFE0001));
    // store 0x40, ack in fifth BUSY cycle; read data on the bus is ignored
    vecs.push_back(mk(1, 0, 1, 32'h40, 32'h12345678,     0, 32'h0,        1, 0, 0, 32'h10,  32'h0,        32'hCAFE0001));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 1, 32'h40, 32'h12345678,   0, 32'h0,        1, 1, 1, 32'h40, 32'h12345678, 32'hCAFE0001));
    vecs.push_back(mk(1, 0, 1, 32'h40, 32'h12345678,     1, 32'hBAD0BAD0, 1, 1, 1, 32'h40, 32'h12345678, 32'hCAFE0001));
    vecs.push_back(mk(1, 0, 1, 32'h40, 32'h12345678,     0, 32'h0,        0, 0, 1, 32'h40, 32'h12345678, 32'hCAFE0001));
    // load held 4 stalled cycles (k=3), then back-to-back load at N+k+2
    vecs.push_back(mk(1, 1, 0, 32'h100,    32'h0,        0, 32'h0,        1, 0, 1, 32'h40, 32'h12345678, 32'hCAFE0001));
    vecs.push_back(mk(1, 1, 0, 32'h100,    32'h0,        0, 32'h0,        1, 1, 0, 32'h100, 32'h0,        32'hCAFE0001));
    vecs.push_back(mk(1, 1, 0, 32'h100,    32'h0,        0, 32'h0,        1, 1, 0, 32'h100, 32'h0,        32'hCAFE0001));
    vecs.push_back(mk(1, 1, 0, 32'h100,    32'h0,        1, 32'h11112222, 1, 1, 0, 32'h100, 32'h0,        32'hCAFE0001));
    vecs.push_back(mk(1, 1, 0, 32'h100,    32'h0,        0, 32'h0,        0, 0, 0, 32'h100, 32'h0,        32'h11112222));
    vecs.push_back(mk(1, 1, 0, 32'h204,    32'h0,        0, 32'h0,        1, 0, 0, 32'h100, 32'h0,        32'h11112222));
    vecs.push_back(mk(1, 1, 0, 32'h204,    32'h0,        1, 32'h33334444, 1, 1, 0, 32'h204, 32'h0,        32'h11112222));
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 0, 32'h204, 32'h0,        32'h33334444));
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 0, 32'h204, 32'h0,        32'h33334444));
    // read and write both high: write issued, rdata_o untouched
    vecs.push_back(mk(1, 1, 1, 32'h80, 32'hA5A5A5A5,     0, 32'h0,        1, 0, 0, 32'h204, 32'h0,        32'h33334444));
    vecs.push_back(mk(1, 1, 1, 32'h80, 32'hA5A5A5A5,     1, 32'hFFFFFFFF, 1, 1, 1, 32'h80, 32'hA5A5A5A5, 32'h33334444));
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 1, 32'h80, 32'hA5A5A5A5, 32'h33334444));
    // stray ack in IDLE
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        1, 32'h99999999, 0, 0, 1, 32'h80, 32'hA5A5A5A5, 32'h33334444));
    // reset while BUSY, then a late ack
    vecs.push_back(mk(1, 1, 0, 32'h300,    32'h0,        0, 32'h0,        1, 0, 1, 32'h80, 32'hA5A5A5A5, 32'h33334444));
    vecs.push_back(mk(1, 1, 0, 32'h300,    32'h0,        0, 32'h0,        1, 1, 0, 32'h300, 32'h0,        32'h33334444));
    vecs.push_back(mk(0, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        1, 32'h77777777, 0, 0, 0, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0));

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      rst_i = vecs[i].rst;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].ack, vecs[i].mrd);
      @(negedge clk_i);
      check($sformatf("v%0d.stall", i), 32'(stall_o),   32'(vecs[i].stall));
      check($sformatf("v%0d.req", i),   32'(mem_req_o), 32'(vecs[i].req));
      check($sformatf("v%0d.we", i),    32'(mem_we_o),  32'(vecs[i].we));
      check($sformatf("v%0d.addr", i),  mem_addr_o,     vecs[i].maddr);
      check($sformatf("v%0d.wdata", i), mem_wdata_o,    vecs[i].mwd);
      check($sformatf("v%0d.rdata", i), rdata_o,        vecs[i].rdata);
      check($sformatf("v%0d.err", i),   32'(err_o),     32'h0);
    end

    // Load with bounded wait for the bus request, ack in second BUSY cycle.
    begin
      bit got = 0;
      @(posedge clk_i); #1;
      drive(1, 0, 32'h3FE, 0, 0, 0);
      for (int n = 0; n < 6 && !got; n++) begin
        @(negedge clk_i);
        if (mem_req_o) got = 1;
      end
      check("seq.req_seen", 32'(got), 32'h1);
      check("seq.addr", mem_addr_o, 32'h3FC);
      @(posedge clk_i); #1;
      drive(1, 0, 32'h3FE, 0, 1, 32'h5A5A0000);
      @(posedge clk_i); #1;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      check("seq.done_stall", 32'(stall_o), 32'h0);
      check("seq.done_req", 32'(mem_req_o), 32'h0);
      check("seq.rdata", rdata_o, 32'h5A5A0000);
    end

`ifdef DMEM_TIMEOUT_EN
    // No ack: request must drop after 8 BUSY cycles with the error flag set.
    begin
      int  req_cycles = 0;
      bit  ended = 0;
      @(posedge clk_i); #1;
      drive(1, 0, 32'h500, 0, 0, 0);
      for (int n = 0; n < 20 && !ended; n++) begin
        @(negedge clk_i);
        if (mem_req_o) req_cycles++;
        else if (req_cycles > 0) ended = 1;
      end
      check("to.ended", 32'(ended), 32'h1);
      check("to.req_cycles", 32'(req_cycles), 32'd8);
      check("to.err", 32'(err_o), 32'h1);
      check("to.rdata", rdata_o, 32'hDEADBEEF);
      check("to.stall", 32'(stall_o), 32'h0);
      @(posedge clk_i); #1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk_i);
      check("to.err_sticky", 32'(err_o), 32'h1);
      check("to.req_idle", 32'(mem_req_o), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port.md
# dmem_port

Memory-stage access controller; the consumer of the EX/MEM pipeline register's M-control, ALU-address and write-data outputs. Turns a single-cycle MemRead/MemWrite request into a registered req/ack transaction on the data-memory bus. Holds the pipeline with `stall_o` until the access completes, then presents load data to MEM/WB for exactly one cycle.

## Interface
- `TIMEOUT_CYCLES`, 64: BUSY cycles without ack before abort (used only with the macro).
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  32  ALU result, byte address.
- `wdata_i`  in  32  store data from EX/MEM.
- `stall_o`  out  1  freeze IF/ID/EX and EX/MEM while high.
- `rdata_o`  out  32  load data to MEM/WB.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  32  bus address, `[1:0]` forced 0.
- `mem_wdata_o`  out  32  bus write data.
- `mem_ack_i`  in  1  bus completion; single-cycle pulse.
- `mem_rdata_i`  in  32  read data, valid with ack.
- `err_o`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `MemRead_i | MemWrite_i` -> latch `addr_i` (bits [1:0] cleared), `wdata_i` and `we = MemWrite_i`, then go to BUSY.
  - No request -> stay in IDLE.
- Both MemRead_i and MemWrite_i high: write wins, and `rdata_o` is not updated.
- BUSY:
  - `mem_req_o = 1`; address, data and we are held stable.
  - On `mem_ack_i`: for a read, capture `mem_rdata_i` into `rdata_o`; then go to DONE.
- DONE:
  - Lasts one cycle with `stall_o = 0`, so the pipeline advances past the served instruction.
  - Then unconditionally return to IDLE. The new EX/MEM contents are evaluated in IDLE on the following cycle, so a held request is never issued twice.
- `stall_o` is combinational: `(IDLE & (MemRead_i | MemWrite_i)) | BUSY`.
- `mem_ack_i` outside BUSY is ignored.
- `rdata_o` holds its last value between loads; stores leave it unchanged.
- Reset (any state, mid-transaction included): state goes to IDLE immediately, `mem_req_o` drops, and the transaction is discarded.
- Reset values: `stall_o` 0 (combinational, with no request pending), `mem_req_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `rdata_o` 0, `err_o` 0.

## Timing
- Cycle N: request seen in IDLE; `stall_o` is high in the same cycle.
- Cycle N+1: `mem_req_o` high from a register output; the earliest ack is in this same cycle.
- Ack in cycle N+k (k ≥ 1): DONE in N+k+1, with `rdata_o` valid and `stall_o` low; the pipeline registers advance at the end of N+k+1.
- Minimum access is 3 cycles, of which `stall_o` is high for 2.
- Back-to-back memory instructions: the next request is seen in IDLE at N+k+2. There are no idle bus cycles beyond that.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter runs in BUSY.
  - When `TIMEOUT_CYCLES` consecutive cycles pass without ack: drop `mem_req_o`, set `err_o` (sticky until reset), go to DONE with `rdata_o = 32'hDEADBEEF` for reads.
  - The counter clears on entry to BUSY.
  - An ack arriving in the timeout cycle wins: normal completion, no error.
- `DMEM_TIMEOUT_EN` undefined: BUSY waits indefinitely, `err_o` is tied to 0, and no counter is synthesized.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE/BUSY/DONE);
  - constant `DMEM_ERR_DATA = 32'hDEADBEEF`;
  - default timeout constant.
- Sub-module `dmem_timeout`: counter with clear/enable inputs and an `expired` output; instantiated only under `DMEM_TIMEOUT_EN`.
- Everything else (FSM and request/data registers) stays in `dmem_port`.

## Test plan
- Load, addr 0x0000_0013, ack one cycle after req with rdata 0xCAFE_0001:
  - `mem_addr_o` = 0x0000_0010, `mem_we_o` = 0;
  - `stall_o` high for 2 cycles;
  - `rdata_o` = 0xCAFE_0001 in the DONE cycle.
- Store, addr 0x40, data 0x1234_5678, ack delayed 5 cycles:
  - `mem_we_o` = 1; address and data stable for all 5 BUSY cycles;
  - `stall_o` high for 6 cycles;
  - `rdata_o` unchanged.
- Request held for 4 cycles while stalled, followed by a second load:
  - exactly one bus transaction for the first instruction;
  - the second request issues at N+k+2.
- MemRead_i and MemWrite_i both high:
  - write transaction issued;
  - `rdata_o` keeps its prior value.
- `rst_i` low while in BUSY:
  - `mem_req_o` low in the same cycle;
  - all outputs at reset values;
  - a later ack is ignored.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, no ack:
  - req drops after 8 cycles;
  - `err_o` = 1 and stays set;
  - `rdata_o` = 0xDEAD_BEEF.
